vs_capture: RTL and testbench
=============================

Name: vs_capture

Overview:
Capture controller that sits directly upstream of the 4Kx12 value-storage RAM. It takes the 12-bit monitor sample stream and writes it into the RAM write port as a circular buffer. On an external or level-crossing trigger it writes a programmable number of post-trigger samples, then freezes the buffer. It reports the trigger and end addresses so downstream readback can reconstruct the time-ordered record.

Parameters:
ADDR_WIDTH, 12, RAM address width (4096 entries)
DATA_WIDTH, 12, sample and RAM word width

Ports:
clk  input  1  system clock, shared with the RAM
reset  input  1  asynchronous, active-high reset
arm  input  1  one-cycle pulse; starts a new capture
abort  input  1  one-cycle pulse; stops capture and returns to IDLE
trig_ext  input  1  external trigger pulse
trig_level_en  input  1  enables the rising level-crossing trigger
trig_level  input  DATA_WIDTH  level-crossing threshold
post_count  input  ADDR_WIDTH  samples to write after the trigger sample
sample_valid  input  1  sample_data is valid this cycle
sample_data  input  DATA_WIDTH  monitor sample
ram_waddr  output  ADDR_WIDTH  RAM write address
ram_wdata  output  DATA_WIDTH  RAM write data
ram_wen  output  1  RAM write enable, active-high
busy  output  1  high in ARMED or POST
done  output  1  high in DONE
wrapped  output  1  buffer pointer has wrapped at least once since arm
trig_addr  output  ADDR_WIDTH  address of the trigger sample
end_addr  output  ADDR_WIDTH  address of the last written sample

Behaviour:
- Clock is clk. reset is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, write pointer 0, trigger-pending flag 0, previous-sample-valid flag 0.
- States and transitions:
  - IDLE --arm--> ARMED
  - ARMED --trigger sample written--> POST, or to DONE if the latched post_count is 0
  - POST --remaining count reaches 0--> DONE
  - DONE --arm--> ARMED
  - abort in any state --> IDLE
  - arm while ARMED or POST restarts the capture (same actions as arm from IDLE).
- On arm:
  - Latch post_count.
  - Clear the write pointer, wrapped, trig_addr, end_addr, trigger-pending flag and previous-sample-valid flag.
- Write path:
  - In ARMED or POST, each cycle with sample_valid registers ram_waddr, ram_wdata and ram_wen=1 on the next edge. Latency is 1 cycle.
  - The write pointer then increments modulo 2^ADDR_WIDTH. wrapped sets when the pointer goes from 4095 to 0.
  - ram_wen is 0 in every cycle without a qualifying sample, and in IDLE and DONE.
  - end_addr updates with every write.
- Trigger qualification (ARMED only):
  - trig_ext sets a pending flag.
  - The trigger sample is the first valid sample in the same cycle as trig_ext or later.
  - Level trigger (when trig_level_en is high): fires when prev < trig_level and cur >= trig_level. It requires a previous valid sample since arm, so the first sample after arm never fires.
  - When both trigger sources fire on the same sample, it is one trigger.
  - Triggers in POST, DONE or IDLE are ignored, and the pending flag clears on leaving ARMED.
- POST behaviour:
  - trig_addr is the address the trigger sample is written to.
  - A down-counter loads post_count when the trigger sample is written and decrements per written sample.
  - The transition to DONE occurs on the edge that issues the last write.
  - post_count 4095 is the maximum; the trigger sample is never overwritten. post_count 0 means the trigger sample is the last write.
- Abort:
  - No further writes after the abort cycle. A write already registered completes.
  - trig_addr, end_addr and wrapped hold their values.
- Simultaneous events: abort beats arm. arm together with sample_valid discards that sample.
- DONE holds all address and status outputs until the next arm, abort or reset.

Decomposition:
- Package vs_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults
  - state encoding localparams (IDLE=0, ARMED=1, POST=2, DONE=3)
- One sub-module, vs_trig_detect: holds the previous-sample register, the level-crossing compare and the external pending flag. It outputs trig_hit qualified by sample_valid, and exposes a clear input driven on arm and on leaving ARMED.

Test Plan:
- Reset asserted mid-POST -> ram_wen, busy, done, trig_addr and end_addr go to 0 without waiting for a clock edge; after release, state is IDLE and ram_wen stays 0.
- arm, then 10 valid samples 0..9, trig_ext with sample 5, post_count=3 -> writes to addresses 0..8 (sample 9 is not written); trig_addr=5, end_addr=8, done=1, wrapped=0.
- arm, level=0x800, level enabled, samples 0x7FF then 0x800, post_count=0 -> trigger on the second sample at addr 1, done the following cycle, end_addr=1.
- arm, 5000 samples with no trigger, then trig_ext, post_count=4095 -> wrapped=1; trigger at addr 904 (5000 mod 4096); end_addr=903; the trigger sample is not overwritten.
- trig_ext on the first post-arm sample with trig_level_en=1 and first sample above level -> single trigger from trig_ext at addr 0; the level path does not fire.
- abort and arm in the same cycle during POST -> state IDLE, no write on the next cycle, trig_addr retained.

Source files
------------

// File: rtl/vs_pkg.sv
// vs_pkg: shared widths and capture state encoding
package vs_pkg;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 12;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ARMED = ST_ARMED,
        POST  = ST_POST,
        DONE  = ST_DONE
    } state_t;
endpackage

// File: rtl/vs_capture_if.sv
// vs_capture_if: monitor sample stream in, value-storage RAM write port out
interface vs_capture_if #(
    parameter int ADDR_WIDTH = vs_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = vs_pkg::DEF_DATA_WIDTH
);
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample_data;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_wen;
    modport master (
        input  sample_valid, sample_data,
        output ram_waddr, ram_wdata, ram_wen
    );
    modport slave (
        output sample_valid, sample_data,
        input  ram_waddr, ram_wdata, ram_wen
    );
endinterface

// File: rtl/vs_trig_detect.sv
// vs_trig_detect: external-pending and rising level-crossing trigger qualification
module vs_trig_detect import vs_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic                  sample_valid_i,
    input  logic [DATA_WIDTH-1:0] sample_data_i,
    input  logic                  trig_ext_i,
    input  logic                  trig_level_en_i,
    input  logic [DATA_WIDTH-1:0] trig_level_i,
    output logic                  trig_hit_o
);
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  prev_vld_q, prev_vld_d;
    logic                  pend_q, pend_d;
    logic                  level_hit;

    // A level hit needs a sample seen since arm; a pending external pulse waits for the next valid sample
    always_comb begin
        level_hit  = trig_level_en_i && prev_vld_q && (prev_q < trig_level_i) && (sample_data_i >= trig_level_i);
        trig_hit_o = en_i && sample_valid_i && (trig_ext_i || pend_q || level_hit);
        pend_d     = !clr_i && en_i && (pend_q || trig_ext_i) && !trig_hit_o;
        prev_vld_d = clr_i ? 1'b0 : (prev_vld_q || (en_i && sample_valid_i));
        prev_d     = (!clr_i && en_i && sample_valid_i) ? sample_data_i : prev_q;
    end

    // Trigger history registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            pend_q     <= pend_d;
        end
    end
endmodule

// File: rtl/vs_capture.sv
// vs_capture: circular-buffer capture into the value-storage RAM with post-trigger freeze
module vs_capture import vs_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trig_ext,
    input  logic                  trig_level_en,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic [ADDR_WIDTH-1:0] post_count,
    vs_capture_if.master          bus,
    output logic                  busy,
    output logic                  done,
    output logic                  wrapped,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] end_addr
);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] post_q, post_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wen_q, wen_d;
    logic                  wrapped_q, wrapped_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0] end_addr_q, end_addr_d;
    logic                  wr, fire, trig_hit, clr;

    vs_trig_detect #(.DATA_WIDTH(DATA_WIDTH)) u_trig (
        .clk             (clk),
        .reset           (reset),
        .clr_i           (clr),
        .en_i            (state_q == ARMED),
        .sample_valid_i  (bus.sample_valid),
        .sample_data_i   (bus.sample_data),
        .trig_ext_i      (trig_ext),
        .trig_level_en_i (trig_level_en),
        .trig_level_i    (trig_level),
        .trig_hit_o      (trig_hit)
    );

    // Next state and datapath: abort beats arm, and a sample arriving with arm or abort is dropped
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        post_d      = post_q;
        cnt_d       = cnt_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wen_d       = 1'b0;
        wrapped_d   = wrapped_q;
        trig_addr_d = trig_addr_q;
        end_addr_d  = end_addr_q;
        wr          = (state_q == ARMED || state_q == POST) && bus.sample_valid && !arm && !abort;
        fire        = wr && (state_q == ARMED) && trig_hit;
        if (abort) begin
            state_d = IDLE;
        end else if (arm) begin
            state_d     = ARMED;
            post_d      = post_count;
            wptr_d      = '0;
            wrapped_d   = 1'b0;
            trig_addr_d = '0;
            end_addr_d  = '0;
        end else if (wr) begin
            wen_d      = 1'b1;
            waddr_d    = wptr_q;
            wdata_d    = bus.sample_data;
            wptr_d     = wptr_q + 1'b1;
            end_addr_d = wptr_q;
            wrapped_d  = wrapped_q || (&wptr_q);
            if (fire) begin
                trig_addr_d = wptr_q;
                cnt_d       = post_q;
                state_d     = (post_q == '0) ? DONE : POST;
            end else if (state_q == POST) begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == ADDR_WIDTH'(1)) ? DONE : POST;
            end
        end
        clr = arm || (state_q == ARMED && state_d != ARMED);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            post_q      <= '0;
            cnt_q       <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            wrapped_q   <= 1'b0;
            trig_addr_q <= '0;
            end_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            post_q      <= post_d;
            cnt_q       <= cnt_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            wrapped_q   <= wrapped_d;
            trig_addr_q <= trig_addr_d;
            end_addr_q  <= end_addr_d;
        end
    end

    assign bus.ram_waddr = waddr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_wen   = wen_q;
    assign busy          = (state_q == ARMED) || (state_q == POST);
    assign done          = (state_q == DONE);
    assign wrapped       = wrapped_q;
    assign trig_addr     = trig_addr_q;
    assign end_addr      = end_addr_q;
endmodule

// File: tb/tb_vs_capture.sv
// tb_vs_capture: directed stimulus with a write scoreboard for vs_capture
module tb_vs_capture;
    localparam int AW = 12;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          trig_ext = 1'b0;
    logic          trig_level_en = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic [AW-1:0] post_count = '0;
    logic          busy, done, wrapped;
    logic [AW-1:0] trig_addr, end_addr;

    vs_capture_if bus();

    vs_capture dut (
        .clk           (clk),
        .reset         (reset),
        .arm           (arm),
        .abort         (abort),
        .trig_ext      (trig_ext),
        .trig_level_en (trig_level_en),
        .trig_level    (trig_level),
        .post_count    (post_count),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .wrapped       (wrapped),
        .trig_addr     (trig_addr),
        .end_addr      (end_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mw;
    int  errors = 0;
    int  checks = 0;

    // Monitor: every RAM write must match the oldest expected write
    always @(negedge clk) begin
        if (!reset && bus.ram_wen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write: unexpected write addr=%0d data=%03h", bus.ram_waddr, bus.ram_wdata);
            end else begin
                mw = exp_q.pop_front();
                if (mw.a !== bus.ram_waddr || mw.d !== bus.ram_wdata) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%03h expected addr=%0d data=%03h",
                             bus.ram_waddr, bus.ram_wdata, mw.a, mw.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm(input logic [AW-1:0] pc);
        post_count = pc;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic smp(input logic v, input logic [DW-1:0] d, input logic te, input bit expw, input logic [AW-1:0] ea);
        wr_t w;
        bus.sample_valid = v;
        bus.sample_data  = d;
        trig_ext         = te;
        if (expw) begin
            w.a = ea;
            w.d = d;
            exp_q.push_back(w);
        end
        cyc();
        bus.sample_valid = 1'b0;
        trig_ext         = 1'b0;
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        #2 reset = 1'b1;
        #1;
        chk("rst_wen", bus.ram_wen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_trig_addr", trig_addr, 0);
        chk("rst_end_addr", end_addr, 0);
        chk("rst_waddr", bus.ram_waddr, 0);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        // External trigger on sample 5, three post samples
        trig_level_en = 1'b0;
        pulse_arm(12'd3);
        chk("t2_busy_armed", busy, 1);
        for (int i = 0; i < 10; i++) smp(1'b1, DW'(i), i == 5, i <= 8, AW'(i));
        cyc();
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        chk("t2_trig_addr", trig_addr, 5);
        chk("t2_end_addr", end_addr, 8);
        chk("t2_wrapped", wrapped, 0);
        chk("t2_q_empty", exp_q.size(), 0);

        // Level crossing on the second sample, post_count 0; the sample alongside arm is dropped
        trig_level    = 12'h800;
        trig_level_en = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 12'h7FE;
        pulse_arm(12'd0);
        bus.sample_valid = 1'b0;
        smp(1'b1, 12'h7FF, 1'b0, 1'b1, 12'd0);
        chk("t3_done_early", done, 0);
        chk("t3_busy", busy, 1);
        smp(1'b1, 12'h800, 1'b0, 1'b1, 12'd1);
        chk("t3_done", done, 1);
        chk("t3_trig_addr", trig_addr, 1);
        chk("t3_end_addr", end_addr, 1);
        smp(1'b1, 12'h900, 1'b0, 1'b0, 12'd0);
        cyc();
        chk("t3_q_empty", exp_q.size(), 0);

        // trig_ext on the first sample which is also above the level
        trig_level    = 12'h100;
        trig_level_en = 1'b1;
        pulse_arm(12'd2);
        smp(1'b1, 12'h900, 1'b1, 1'b1, 12'd0);
        chk("t5_trig_addr", trig_addr, 0);
        smp(1'b1, 12'h050, 1'b0, 1'b1, 12'd1);
        smp(1'b1, 12'h200, 1'b0, 1'b1, 12'd2);
        smp(1'b1, 12'h300, 1'b0, 1'b0, 12'd0);
        cyc();
        chk("t5_done", done, 1);
        chk("t5_trig_addr_final", trig_addr, 0);
        chk("t5_end_addr", end_addr, 2);
        chk("t5_q_empty", exp_q.size(), 0);

        // Pending external trigger, then abort together with arm during POST
        trig_level_en = 1'b0;
        pulse_arm(12'd20);
        smp(1'b1, 12'h111, 1'b0, 1'b1, 12'd0);
        smp(1'b0, 12'h000, 1'b1, 1'b0, 12'd0);
        chk("t6_no_early_trig", busy, 1);
        smp(1'b1, 12'h222, 1'b0, 1'b1, 12'd1);
        chk("t6_trig_addr", trig_addr, 1);
        smp(1'b1, 12'h333, 1'b0, 1'b1, 12'd2);
        abort = 1'b1;
        arm   = 1'b1;
        smp(1'b1, 12'h444, 1'b0, 1'b0, 12'd0);
        abort = 1'b0;
        arm   = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_wen", bus.ram_wen, 0);
        chk("t6_trig_keep", trig_addr, 1);
        chk("t6_end_keep", end_addr, 2);
        smp(1'b1, 12'h555, 1'b1, 1'b0, 12'd0);
        chk("t6_idle_wen", bus.ram_wen, 0);
        cyc();
        chk("t6_q_empty", exp_q.size(), 0);

        // 5000 untriggered samples, trigger at 904, maximum post_count
        pulse_arm(12'd4095);
        for (int i = 0; i < 5000; i++) begin
            smp(1'b1, DW'((i * 5 + 3) & 12'hFFF), 1'b0, 1'b1, AW'(i % 4096));
            if (i == 4094) chk("t4_wrapped_pre", wrapped, 0);
            if (i == 4095) chk("t4_wrapped_post", wrapped, 1);
        end
        smp(1'b1, 12'hABC, 1'b1, 1'b1, 12'd904);
        chk("t4_trig_addr", trig_addr, 904);
        for (int j = 1; j <= 4095; j++) smp(1'b1, DW'((j * 3 + 7) & 12'hFFF), 1'b0, 1'b1, AW'((904 + j) % 4096));
        chk("t4_done", done, 1);
        chk("t4_end_addr", end_addr, 903);
        chk("t4_wrapped", wrapped, 1);
        smp(1'b1, 12'hFFF, 1'b0, 1'b0, 12'd0);
        cyc();
        chk("t4_trig_final", trig_addr, 904);
        chk("t4_q_empty", exp_q.size(), 0);

        // Asynchronous reset while a POST write is on the bus
        pulse_arm(12'd10);
        smp(1'b1, 12'h0A1, 1'b1, 1'b1, 12'd0);
        smp(1'b1, 12'h0A2, 1'b0, 1'b1, 12'd1);
        smp(1'b1, 12'h0A3, 1'b0, 1'b1, 12'd2);
        chk("t1_wen_before", bus.ram_wen, 1);
        #5;
        reset = 1'b1;
        #1;
        chk("t1_wen", bus.ram_wen, 0);
        chk("t1_busy", busy, 0);
        chk("t1_done", done, 0);
        chk("t1_trig_addr", trig_addr, 0);
        chk("t1_end_addr", end_addr, 0);
        cyc();
        reset = 1'b0;
        chk("t1_idle_busy", busy, 0);
        for (int k = 0; k < 3; k++) smp(1'b1, DW'(12'h0B0 + k), 1'b1, 1'b0, 12'd0);
        chk("t1_idle_wen", bus.ram_wen, 0);
        cyc();
        chk("t1_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
